// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; flags the handshake that
// carries the last byte of each word.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (shift_i) begin
      shreg_d = {shreg_q[23:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // The word is presented combinationally so the top can register it on the
  // same edge that accepts the final byte.
  assign word_o          = shreg_d;
  assign word_complete_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program image into instruction memory and holds the
// core in reset until the image is verified.
module imem_loader
  import loader_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WIDTH-1:0]  im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        nhi_q, nhi_d;
  logic [15:0]       rem_q, rem_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [WIDTH-1:0]  im_wdata_q, im_wdata_d;
  logic [15:0]       words_q, words_d;

  logic        hs;
  logic        pack_shift;
  logic [31:0] pack_word;
  logic        pack_complete;
  logic [15:0] n_hdr;

  assign in_ready   = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                      (state_q == DATA)   || (state_q == CHK);
  assign hs         = in_valid && in_ready;
  assign pack_shift = hs && (state_q == DATA);
  assign n_hdr      = {nhi_q, in_data};

  word_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .shift_i         (pack_shift),
    .byte_i          (in_data),
    .word_o          (pack_word),
    .word_complete_o (pack_complete)
  );

  always_comb begin
    state_d    = state_q;
    xor_d      = xor_q;
    nhi_d      = nhi_q;
    rem_d      = rem_q;
    waddr_d    = waddr_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    words_d    = words_q + 16'(im_we_q);

    case (state_q)
      HDR_HI: begin
        if (hs) begin
          nhi_d   = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (hs) begin
          xor_d = xor_q ^ in_data;
          rem_d = n_hdr;
          if (n_hdr > DEPTH_W)     state_d = ERROR;
          else if (n_hdr == 16'd0) state_d = CHK;
          else                     state_d = DATA;
        end
      end
      DATA: begin
        if (hs) begin
          xor_d = xor_q ^ in_data;
          if (pack_complete) begin
            im_we_d    = 1'b1;
            im_addr_d  = waddr_q;
            im_wdata_d = WIDTH'(pack_word);
            waddr_d    = waddr_q + 1'b1;
            rem_d      = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (hs) state_d = (in_data == xor_q) ? RUN : ERROR;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR_HI;
      xor_q      <= '0;
      nhi_q      <= '0;
      rem_q      <= '0;
      waddr_q    <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      xor_q      <= xor_d;
      nhi_q      <= nhi_d;
      rem_q      <= rem_d;
      waddr_q    <= waddr_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      words_q    <= words_d;
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign words_loaded = words_q;
  assign done         = (state_q == RUN);
  assign err          = (state_q == ERROR);
  assign core_rst     = (state_q != RUN);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, hand-written corner sequences and
// randomized images checked against a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  imem_loader #(.WIDTH(32), .DEPTH(64), .ADDR_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stream_q[$];
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          pulse_viol = 0;
  bit          prev_we = 1'b0;

  // Write-port monitor: captures every pulse and flags any pulse longer than a cycle.
  always @(negedge clk) begin
    if (im_we) begin
      log_addr.push_back(im_addr);
      log_data.push_back(im_wdata);
      if (prev_we) pulse_viol++;
    end
    prev_we = im_we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    pulse_viol = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_im_we"}, 32'(im_we), 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    $display("[TB] %s: reset state checked", tag);
  endtask

  task automatic send(input logic [7:0] b, input int gap, output bit ok);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] stream_xor(input int upto);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < upto; i++) x ^= stream_q[i];
    return x;
  endfunction

  // Sends stream_q; checks write timing after each word's last byte and the
  // header/checksum outcome on the cycle after the deciding byte.
  task automatic run_stream(input int maxgap, input string tag);
    bit ok;
    int n;
    int gap;
    logic [31:0] w;
    n = -1;
    for (int i = 0; i < stream_q.size(); i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send(stream_q[i], gap, ok);
      if (!ok) begin
        chk({tag, "_handshake_timeout"}, 32'd0, 32'd1);
        break;
      end
      if (i == 1) begin
        n = int'({stream_q[0], stream_q[1]});
        if (n > 64) begin
          chk({tag, "_oversize_err"}, 32'(err), 32'd1);
          chk({tag, "_oversize_ready"}, 32'(in_ready), 32'd0);
        end
      end
      if (n >= 0 && n <= 64 && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
        w = {stream_q[i-3], stream_q[i-2], stream_q[i-1], stream_q[i]};
        chk($sformatf("%s_we_w%0d", tag, (i - 2) / 4), 32'(im_we), 32'd1);
        chk($sformatf("%s_addr_w%0d", tag, (i - 2) / 4), 32'(im_addr), 32'((i - 2) / 4));
        chk($sformatf("%s_data_w%0d", tag, (i - 2) / 4), im_wdata, w);
      end
      if (n >= 0 && n <= 64 && i == 2 + 4 * n) begin
        chk({tag, "_chk_done"}, 32'(done), 32'(stream_q[i] == stream_xor(i)));
        chk({tag, "_chk_core_rst"}, 32'(core_rst), 32'(stream_q[i] != stream_xor(i)));
      end
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Reference model: expected writes and final status derived from the stream rules.
  task automatic check_result(input string tag);
    int n;
    int ew;
    bit ed;
    n = int'({stream_q[0], stream_q[1]});
    if (n > 64) begin
      ew = 0;
      ed = 1'b0;
    end else begin
      ew = n;
      ed = (stream_q[4 * n + 2] == stream_xor(4 * n + 2));
    end
    chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'(ew));
    for (int k = 0; k < ew && k < log_addr.size(); k++) begin
      chk($sformatf("%s_log_addr%0d", tag, k), 32'(log_addr[k]), 32'(k));
      chk($sformatf("%s_log_data%0d", tag, k), log_data[k],
          {stream_q[2+4*k], stream_q[3+4*k], stream_q[4+4*k], stream_q[5+4*k]});
    end
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_err"}, 32'(err), 32'(!ed));
    chk({tag, "_core_rst"}, 32'(core_rst), 32'(!ed));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(ew));
    chk({tag, "_pulse_width"}, 32'(pulse_viol), 32'd0);
    $display("[TB] %s: N=%0d writes=%0d done=%0b err=%0b", tag, n, log_addr.size(), done, err);
  endtask

  typedef struct {
    string       name;
    int          nb;
    logic [95:0] bytes;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          d;
    bit          e;
  } vec_t;

  vec_t vt[5];

  task automatic load_vec(input vec_t v);
    stream_q.delete();
    for (int i = 0; i < v.nb; i++) stream_q.push_back(v.bytes[(v.nb - 1 - i) * 8 +: 8]);
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0] cs;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_reset("reset");

    vt[0] = '{"normal",   11, 96'h00_02_20_08_00_05_20_09_00_0A_0C, 2, 32'h20080005, 32'h2009000A, 1'b1, 1'b0};
    vt[1] = '{"bad_cs",   11, 96'h00_02_20_08_00_05_20_09_00_0A_0D, 2, 32'h20080005, 32'h2009000A, 1'b0, 1'b1};
    vt[2] = '{"oversize",  2, 96'h00_41,                            0, 32'h0,        32'h0,        1'b0, 1'b1};
    vt[3] = '{"empty",     3, 96'h00_00_00,                         0, 32'h0,        32'h0,        1'b1, 1'b0};
    vt[4] = '{"one_word",  7, 96'h00_01_DE_AD_BE_EF_23,             1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};

    for (int r = 0; r < 5; r++) begin
      do_reset();
      load_vec(vt[r]);
      run_stream(0, vt[r].name);
      chk({vt[r].name, "_nwrites"}, 32'(log_addr.size()), 32'(vt[r].nw));
      if (vt[r].nw > 0 && log_addr.size() > 0) begin
        chk({vt[r].name, "_addr0"}, 32'(log_addr[0]), 32'd0);
        chk({vt[r].name, "_w0"}, log_data[0], vt[r].w0);
      end
      if (vt[r].nw > 1 && log_addr.size() > 1) begin
        chk({vt[r].name, "_addr1"}, 32'(log_addr[1]), 32'd1);
        chk({vt[r].name, "_w1"}, log_data[1], vt[r].w1);
      end
      chk({vt[r].name, "_done"}, 32'(done), 32'(vt[r].d));
      chk({vt[r].name, "_err"}, 32'(err), 32'(vt[r].e));
      chk({vt[r].name, "_core_rst"}, 32'(core_rst), 32'(!vt[r].d));
      chk({vt[r].name, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({vt[r].name, "_words"}, 32'(words_loaded), 32'(vt[r].nw));
      $display("[TB] vec %s: writes=%0d done=%0b err=%0b words=%0d",
               vt[r].name, log_addr.size(), done, err, words_loaded);
    end

    // Oversize image: the stream is ignored once in ERROR.
    do_reset();
    load_vec(vt[2]);
    run_stream(0, "oversize_hold");
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("oversize_hold_err", 32'(err), 32'd1);
    chk("oversize_hold_nwrites", 32'(log_addr.size()), 32'd0);
    chk("oversize_hold_words", 32'(words_loaded), 32'd0);
    $display("[TB] oversize_hold: err=%0b writes=%0d", err, log_addr.size());

    // Completed load, then reset: all outputs return to their reset values.
    do_reset();
    load_vec(vt[0]);
    run_stream(0, "run_then_reset");
    check_result("run_then_reset");
    do_reset();
    check_reset("post_run_reset");

    // Gapped delivery of the normal stream.
    do_reset();
    load_vec(vt[0]);
    run_stream(5, "normal_gaps");
    check_result("normal_gaps");

    // Mid-load reset after 5 bytes, then a full reload from address 0.
    do_reset();
    load_vec(vt[0]);
    for (int i = 0; i < 5; i++) begin
      send(stream_q[i], 0, ok);
      if (!ok) chk("midload_timeout", 32'd0, 32'd1);
    end
    do_reset();
    check_reset("midload_reset");
    run_stream(0, "midload_reload");
    check_result("midload_reload");

    // Reset coincident with a handshake: the byte must be dropped.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    log_addr.delete();
    log_data.delete();
    pulse_viol = 0;
    load_vec(vt[3]);
    run_stream(0, "rst_vs_hs");
    check_result("rst_vs_hs");

    // Randomized images: sizes 0..8, full depth, oversize, random corruption and gaps.
    for (int it = 0; it < 24; it++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r <= 8)       n = r;
      else if (r == 9)  n = 64;
      else              n = 65 + int'($urandom_range(0, 200));
      stream_q.delete();
      stream_q.push_back(8'(n >> 8));
      stream_q.push_back(8'(n));
      if (n <= 64) begin
        for (int b = 0; b < 4 * n; b++) stream_q.push_back(8'($urandom));
        cs = stream_xor(4 * n + 2);
        if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
        stream_q.push_back(cs);
      end
      do_reset();
      run_stream(3, $sformatf("rand%0d", it));
      check_result($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
